// File: rtl/write_back_arbiter.sv
// -----------------------------------------------------------------------------
// write_back_arbiter
//
// Shares the register file's single write-back port between NUM_REQ execution
// units. A round-robin arbiter picks at most one requester per cycle, and the
// accepted result is presented to the register file one cycle later through a
// registered output stage. Writes to register 0 are accepted from the
// requester but never strobed into the register file, because r0 is
// hard-wired zero and has no storage cell.
//
// Ports:
//   clk                         clock, all state updates on the rising edge
//   rst                         synchronous reset, active low
//   hold_input                  suppresses any grant in the current cycle
//   req_valid_input             per-requester "result pending"
//   req_register_input          per-requester destination index (slice i)
//   req_result_input            per-requester result data (slice i)
//   req_ready_output            one-hot grant; handshake is valid[i] & ready[i]
//   write_back_output           register-file write strobe
//   write_back_register_output  destination index of the write-back
//   result_output               data of the write-back
//   grant_count_output          wrapping count of accepted handshakes
//   waw_error_output            (only with WB_ARB_WAW_CHECK_EN) sticky flag for
//                               write-after-write hazards on a nonzero register
//
// Optional feature macro: WB_ARB_WAW_CHECK_EN
// -----------------------------------------------------------------------------
module write_back_arbiter #(
    parameter int NUM_REQ                   = 4,
    parameter int REGISTER_DESCRIPTOR_WIDTH = 5,
    parameter int OPERAND_WIDTH             = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   hold_input,
    input  logic [NUM_REQ-1:0]                     req_valid_input,
    input  logic [NUM_REQ*REGISTER_DESCRIPTOR_WIDTH-1:0] req_register_input,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0]       req_result_input,
    output logic [NUM_REQ-1:0]                     req_ready_output,
    output logic                                   write_back_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0]   write_back_register_output,
    output logic [OPERAND_WIDTH-1:0]               result_output,
    output logic [15:0]                            grant_count_output
`ifdef WB_ARB_WAW_CHECK_EN
    ,
    output logic                                   waw_error_output
`endif
);

    localparam int RDW   = REGISTER_DESCRIPTOR_WIDTH;
    localparam int OW    = OPERAND_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);

    // NUM_REQ and the last index expressed in the widths the scan arithmetic uses.
    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ-1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic [PTR_W:0]   scan_sum;
    logic [RDW-1:0]   grant_register;
    logic [OW-1:0]    grant_result;

    logic [RDW-1:0]   req_register [NUM_REQ];
    logic [OW-1:0]    req_result   [NUM_REQ];

    // Split the flat request buses into per-requester views.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_register[i] = req_register_input[i*RDW +: RDW];
        assign req_result[i]   = req_result_input[i*OW +: OW];
    end

    // Round-robin scan: start at ptr and walk upward with wrap-around. The
    // sum is one bit wider than ptr so the wrap is a single conditional
    // subtract, which also works when NUM_REQ is not a power of two. Reset
    // and hold both suppress the grant so no requester retires an entry
    // that the output stage would not capture.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        if (rst && !hold_input) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
                if (scan_sum >= NUM_REQ_EXT) begin
                    scan_sum = scan_sum - NUM_REQ_EXT;
                end
                if (!grant_found && req_valid_input[scan_sum[PTR_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_sum[PTR_W-1:0];
                end
            end
        end
    end

    // One-hot ready derived from the winning index.
    always_comb begin
        req_ready_output = '0;
        if (grant_found) begin
            req_ready_output[grant_idx] = 1'b1;
        end
    end

    assign grant_register = req_register[grant_idx];
    assign grant_result   = req_result[grant_idx];
    assign next_ptr       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Pointer, registered write-back stage and handshake counter. A grant to
    // r0 still advances the pointer and the counter, but the strobe stays low
    // and the data/index registers keep their previous contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr                        <= '0;
            write_back_output          <= 1'b0;
            write_back_register_output <= '0;
            result_output              <= '0;
            grant_count_output         <= '0;
        end else begin
            write_back_output <= 1'b0;
            if (grant_found) begin
                ptr                <= next_ptr;
                grant_count_output <= grant_count_output + 16'd1;
                if (grant_register != '0) begin
                    write_back_output          <= 1'b1;
                    write_back_register_output <= grant_register;
                    result_output              <= grant_result;
                end
            end
        end
    end

`ifdef WB_ARB_WAW_CHECK_EN
    logic dup_target;
    logic waw_hit;

    // Two pending requesters aiming at the same real register means one of
    // the writes will be overtaken by the other in an unknown order.
    always_comb begin
        dup_target = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (req_valid_input[i] && req_valid_input[j] &&
                    (req_register[i] == req_register[j]) &&
                    (req_register[i] != '0)) begin
                    dup_target = 1'b1;
                end
            end
        end
    end

    // A strobed write-back always targets a nonzero register, so matching it
    // against the new grant needs no separate r0 exclusion.
    assign waw_hit = dup_target ||
                     (grant_found && write_back_output &&
                      (grant_register == write_back_register_output));

    // Sticky hazard flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waw_error_output <= 1'b0;
        end else if (waw_hit) begin
            waw_error_output <= 1'b1;
        end
    end
`endif

endmodule
